// File: rtl/spi_pkg.sv
// Shared definitions for the SPI configuration link: FSM encoding, default
// configuration word and the configuration register field layout.
package spi_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP    = 3'd1;
  localparam logic [ST_W-1:0] ST_SHIFT_HI = 3'd2;
  localparam logic [ST_W-1:0] ST_SHIFT_LO = 3'd3;
  localparam logic [ST_W-1:0] ST_HOLD     = 3'd4;
  localparam logic [ST_W-1:0] ST_GAP      = 3'd5;

  localparam int unsigned CFG_W = 32;
  localparam logic [CFG_W-1:0] SPI_DEFAULT_CFG = 32'hBBFC_0000;

  localparam int unsigned CFG_SEL_MSB     = 31;
  localparam int unsigned CFG_SEL_LSB     = 30;
  localparam int unsigned CFG_COLOUR_MSB  = 29;
  localparam int unsigned CFG_COLOUR_LSB  = 24;
  localparam int unsigned CFG_CHAR_WR_BIT = 21;
  localparam int unsigned CFG_CHAR_MSB    = 20;
  localparam int unsigned CFG_CHAR_LSB    = 15;

  // Bit layout of the peripheral's 32-bit configuration register.
  typedef struct packed {
    logic [1:0]  sel;
    logic [5:0]  colour;
    logic [1:0]  rsvd_hi;
    logic        char_wr;
    logic [5:0]  char_code;
    logic [14:0] rsvd_lo;
  } spi_cfg_t;

  function automatic logic [CFG_W-1:0] spi_cfg_pack(input logic [1:0] sel,
                                                    input logic [5:0] colour,
                                                    input logic       char_wr,
                                                    input logic [5:0] char_code);
    spi_cfg_t cfg;
    cfg           = '0;
    cfg.sel       = sel;
    cfg.colour    = colour;
    cfg.char_wr   = char_wr;
    cfg.char_code = char_code;
    return cfg;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Down-counter that times one SPI phase: reload on entry to a state, tick on
// the last of CLK_DIV cycles.
module spi_phase_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_tick_c
);

  localparam int unsigned PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PH_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= PH_W'(CLK_DIV - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - PH_W'(1);
    end
  end

  assign o_tick_c = (r_count == '0);

endmodule

// File: rtl/spi_config_controller.sv
// SPI mode-0 initiator: sends one MSB-first word per accepted request on
// sclk/mosi/ss and assembles the word returned on miso.
module spi_config_controller
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ss
);

  localparam int unsigned BC_W  = $clog2(DATA_WIDTH);
  localparam int unsigned TX_W  = DATA_WIDTH - 1;

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("spi_config_controller: CLK_DIV must be >= 2");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
      $error("spi_config_controller: DATA_WIDTH must be >= 2");
    end
  endgenerate

  logic [ST_W-1:0]       r_state;
  logic [TX_W-1:0]       r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [BC_W-1:0]       r_bit_cnt;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_ss;

  logic [ST_W-1:0]       w_state_nxt;
  logic [TX_W-1:0]       w_tx_nxt;
  logic [DATA_WIDTH-1:0] w_rx_nxt;
  logic [BC_W-1:0]       w_bit_cnt_nxt;
  logic                  w_done_nxt;
  logic [DATA_WIDTH-1:0] w_rx_data_nxt;
  logic                  w_mosi_nxt;
  logic                  w_ss_nxt;
  logic                  w_sclk_nxt;
  logic                  w_ready_nxt;
  logic                  w_load;
  logic                  w_tick;

  // Every state change enters a new timed phase, so it always reloads the timer.
  assign w_load = (w_state_nxt != r_state);

  spi_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .o_tick_c (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_bit_cnt_nxt = r_bit_cnt;
    w_done_nxt    = 1'b0;
    w_rx_data_nxt = r_rx_data;
    w_mosi_nxt    = r_mosi;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_SETUP;
          w_tx_nxt      = tx_data[TX_W-1:0];
          w_mosi_nxt    = tx_data[DATA_WIDTH-1];
          w_rx_nxt      = '0;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_state_nxt = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        // Last high cycle: capture miso just before sclk falls.
        if (w_tick) begin
          w_rx_nxt = {r_rx[DATA_WIDTH-2:0], miso};
          if (r_bit_cnt == BC_W'(DATA_WIDTH - 1)) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt   = ST_SHIFT_LO;
            w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
            w_mosi_nxt    = r_tx[TX_W-1];
            w_tx_nxt      = r_tx << 1;
          end
        end
      end
      ST_SHIFT_LO: begin
        if (w_tick) begin
          w_state_nxt = ST_SHIFT_HI;
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_state_nxt   = ST_GAP;
          w_mosi_nxt    = 1'b0;
          w_rx_data_nxt = r_rx;
          w_done_nxt    = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mosi_nxt  = 1'b0;
      end
    endcase

    w_ss_nxt    = !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT_HI) ||
                    (w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_HOLD));
    w_sclk_nxt  = (w_state_nxt == ST_SHIFT_HI);
    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= !w_ready_nxt;
      r_done    <= w_done_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_ss      <= w_ss_nxt;
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign ss      = r_ss;

endmodule

// File: tb/tb_spi_config_controller.sv
// Bench for spi_config_controller: frame vectors with a done-driven scoreboard,
// back-to-back, ignored-start, mid-frame reset and a CLK_DIV=2 build.
module tb_spi_config_controller;
  import spi_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned DIV     = 4;
  localparam int unsigned DIV2    = 2;
  localparam int unsigned SS_LOW  = DIV * (2 * W + 1);
  localparam int unsigned SS_LOW2 = DIV2 * (2 * W + 1);
  localparam int unsigned SPACING = DIV * (2 * W + 2) + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         ready, busy, done, sclk, mosi, miso, ss;
  logic [W-1:0] rx_data;
  logic [1:0]   m_mode = 2'd0;

  logic         start2 = 1'b0;
  logic [W-1:0] tx2 = '0;
  logic         ready2, busy2, done2, sclk2, mosi2, ss2;
  logic [W-1:0] rx_data2;

  always #5 clk = ~clk;

  // miso source: 0 = tied low, 1 = loopback, 2 = inverted loopback
  assign miso = (m_mode == 2'd1) ? mosi : (m_mode == 2'd2) ? ~mosi : 1'b0;

  spi_config_controller #(.DATA_WIDTH(W), .CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .ready(ready), .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
  );

  spi_config_controller #(.DATA_WIDTH(W), .CLK_DIV(DIV2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(tx2),
    .ready(ready2), .busy(busy2), .done(done2), .rx_data(rx_data2),
    .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .ss(ss2)
  );

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
  } exp_t;

  typedef struct {
    logic [W-1:0] tx;
    logic [1:0]   mode;
    logic [W-1:0] rx;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  int           m_rises = 0;
  int           m_ss_low = 0;
  int           m_ss_high = 0;
  int           m_done_cnt = 0;
  int           m_done_cyc[$];
  bit           m_seen = 1'b0;
  logic         m_prev_sclk = 1'b0;
  logic         m_prev_ss = 1'b1;
  logic [W-1:0] m_word = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Link monitor: decodes mosi at sclk rises and scores each frame at done.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_rises = 0; m_ss_low = 0; m_ss_high = 0; m_seen = 1'b0;
      m_prev_sclk = 1'b0; m_prev_ss = 1'b1; m_word = '0;
      exp_q.delete();
    end else begin
      if (sclk && !m_prev_sclk) begin
        m_word = {m_word[W-2:0], mosi};
        m_rises++;
      end
      if (!ss && m_prev_ss) begin
        if (m_seen) chk("ss_deselect_min", 32'(m_ss_high >= int'(DIV)), 32'd1);
        m_ss_high = 0;
      end
      if (done) begin
        m_done_cnt++;
        m_done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          timeout("unexpected_done");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e.rx);
          chk("mosi_word", m_word, e.tx);
          chk("sclk_rises", 32'(m_rises), 32'(W));
          chk("ss_low_cycles", 32'(m_ss_low), 32'(SS_LOW));
        end
        m_rises = 0; m_ss_low = 0; m_seen = 1'b1;
      end
      if (!ss) m_ss_low++; else m_ss_high++;
      m_prev_sclk = sclk;
      m_prev_ss   = ss;
    end
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ready) return;
    end
    timeout(name);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) return;
    end
    timeout(name);
  endtask

  task automatic drive_frame(input logic [W-1:0] tx, input logic [W-1:0] rx);
    exp_t e;
    wait_ready("ready_before_start");
    e.tx = tx;
    e.rx = rx;
    tx_data = tx;
    start   = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start   = 1'b0;
    tx_data = $urandom;
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t         vecs[7];
    logic [W-1:0] b2b[3];
    int           base, n, cnt;

    vecs[0] = '{SPI_DEFAULT_CFG, 2'd0, 32'h0000_0000};
    vecs[1] = '{32'hA5C3_0F81,   2'd1, 32'hA5C3_0F81};
    vecs[2] = '{spi_cfg_pack(2'b01, 6'd0, 1'b0, 6'd0), 2'd0, 32'h0000_0000};
    vecs[3] = '{32'h1234_5678,   2'd2, 32'hEDCB_A987};
    vecs[4] = '{32'hFFFF_FFFF,   2'd1, 32'hFFFF_FFFF};
    vecs[5] = '{32'h0000_0001,   2'd2, 32'hFFFF_FFFE};
    vecs[6] = '{32'h8000_0000,   2'd1, 32'h8000_0000};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ss", 32'(ss), 32'd1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      base   = m_done_cnt;
      m_mode = vecs[i].mode;
      drive_frame(vecs[i].tx, vecs[i].rx);
      chk("busy_after_accept", 32'(busy), 32'd1);
      wait_done("frame_done");
      wait_ready("frame_ready");
      chk("rx_data_held", rx_data, vecs[i].rx);
      chk("one_done_per_frame", 32'(m_done_cnt - base), 32'd1);
    end

    // Back-to-back frames with start held high; pulses while busy are ignored.
    b2b[0] = 32'h1357_9BDF; b2b[1] = 32'h2468_ACE0; b2b[2] = 32'hDEAD_BEEF;
    base   = m_done_cnt;
    m_mode = 2'd1;
    wait_ready("b2b_ready0");
    start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      exp_t e;
      if (f > 0) wait_ready("b2b_ready");
      tx_data = b2b[f];
      e.tx = b2b[f];
      e.rx = b2b[f];
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      tx_data = $urandom;
    end
    start = 1'b0;
    repeat (3) begin
      repeat (20) @(negedge clk);
      start   = 1'b1;
      tx_data = 32'hFFFF_0000;
      @(negedge clk);
      start   = 1'b0;
    end
    wait_ready("b2b_idle");
    repeat (300) @(negedge clk);
    chk("b2b_done_count", 32'(m_done_cnt - base), 32'd3);
    n = m_done_cyc.size();
    if (n >= 3) begin
      chk("b2b_spacing_1", 32'(m_done_cyc[n-2] - m_done_cyc[n-3]), 32'(SPACING));
      chk("b2b_spacing_2", 32'(m_done_cyc[n-1] - m_done_cyc[n-2]), 32'(SPACING));
    end else begin
      timeout("b2b_done_history");
    end

    // Asynchronous reset while bit 10 is on the wire.
    m_mode = 2'd1;
    drive_frame(32'hA5A5_A5A5, 32'hA5A5_A5A5);
    cnt = 0;
    while (m_rises < 11 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 400) timeout("bit10_reached");
    base = m_done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ss", 32'(ss), 32'd1);
    chk("async_rst_sclk", 32'(sclk), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd1);
    chk("async_rst_rx_data", rx_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("no_done_after_abort", 32'(m_done_cnt - base), 32'd0);
    m_mode = 2'd1;
    drive_frame(32'h0F0F_3C3C, 32'h0F0F_3C3C);
    wait_done("clean_frame_done");
    wait_ready("clean_frame_ready");

    // CLK_DIV=2 build, loopback.
    @(negedge clk);
    tx2    = 32'hC0DE_1234;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    tx2    = 32'h0;
    cnt    = 0;
    begin : div2_wait
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (!ss2) cnt++;
        if (done2) disable div2_wait;
      end
      timeout("div2_done");
    end
    chk("div2_ss_low_cycles", 32'(cnt), 32'(SS_LOW2));
    chk("div2_rx_data", rx_data2, 32'hC0DE_1234);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
